// File: rtl/life_if.sv
// Command/status bundle between the control layer and the life engine.
interface life_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int PER_W = 8,
    parameter int GEN_W = 16
);
    logic [ROWS*COLS-1:0] seed;
    logic                 load;
    logic                 start;
    logic                 stop;
    logic                 step;
    logic [PER_W-1:0]     period;
    logic                 auto_halt;
    logic [ROWS*COLS-1:0] grid;
    logic [GEN_W-1:0]     gen_count;
    logic                 gen_tick;
    logic                 running;
    logic                 stable;
    logic                 extinct;

    modport master (
        output seed, load, start, stop, step, period, auto_halt,
        input  grid, gen_count, gen_tick, running, stable, extinct
    );
    modport slave (
        input  seed, load, start, stop, step, period, auto_halt,
        output grid, gen_count, gen_tick, running, stable, extinct
    );
endinterface

// File: rtl/life_engine.sv
// Conway Game-of-Life (B3/S23) engine over a ROWS x COLS grid.
// The grid register is the only cell storage; the successor generation is
// computed combinationally from it. Free-run with a prescaled period or
// single-step from IDLE. The auto-halt decision at a tick point compares the
// live successor against the grid directly, so it is correct even when the
// grid changed on the previous edge (period 0) and the registered flags lag.
module life_engine #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int WRAP  = 1,
    parameter int PER_W = 8,
    parameter int GEN_W = 16
) (
    input  logic   clk_i,
    input  logic   reset_ni,
    life_if.slave  bus
);
    localparam int N = ROWS * COLS;

    typedef enum logic {IDLE, RUN} state_e;

    state_e           state_q;
    logic [N-1:0]     grid_q;
    logic [N-1:0]     grid_d;     // successor generation
    logic [GEN_W-1:0] gen_q;
    logic [GEN_W-1:0] gen_d;
    logic [PER_W-1:0] pre_q;
    logic             tick_q;
    logic             stable_q;
    logic             extinct_q;
    logic             still;
    logic             dead;

    // Per-cell neighbourhood and rule evaluation.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic [7:0] nb;
            logic [3:0] cnt;
            for (genvar k = 0; k < 8; k++) begin : g_nb
                // k: 0..2 row above, 3..4 same row, 5..7 row below
                localparam int DR  = (k < 3) ? -1 : (k < 5) ? 0 : 1;
                localparam int DC  = (k == 0 || k == 3 || k == 5) ? -1 :
                                     (k == 1 || k == 6) ? 0 : 1;
                localparam int RR  = r + DR;
                localparam int CC  = c + DC;
                localparam bit INR = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                localparam int RW  = (RR + ROWS) % ROWS;
                localparam int CW  = (CC + COLS) % COLS;
                if (WRAP != 0 || INR) begin : g_rd
                    assign nb[k] = grid_q[RW*COLS + CW];
                end else begin : g_zero
                    assign nb[k] = 1'b0;
                end
            end
            // Population count of the 8 neighbours (0..8 fits in 4 bits).
            always_comb begin
                cnt = '0;
                for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, nb[i]};
            end
            assign grid_d[r*COLS + c] = (cnt == 4'd3) | (grid_q[r*COLS + c] & (cnt == 4'd2));
        end
    end

    assign still = (grid_d == grid_q);
    assign dead  = (grid_q == '0);

    // Saturating generation increment.
    always_comb begin
        gen_d = gen_q;
        if (gen_q != {GEN_W{1'b1}}) gen_d = gen_q + 1'b1;
    end

    // Control FSM, grid storage and status flags.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            grid_q    <= '0;
            gen_q     <= '0;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            stable_q  <= 1'b1;
            extinct_q <= 1'b1;
        end else begin
            tick_q    <= 1'b0;
            stable_q  <= still;
            extinct_q <= dead;
            if (bus.load) begin
                grid_q  <= bus.seed;
                gen_q   <= '0;
                pre_q   <= '0;
                state_q <= IDLE;
            end else if (bus.stop) begin
                state_q <= IDLE;
            end else if (bus.start && state_q == IDLE) begin
                state_q <= RUN;
                pre_q   <= '0;
            end else if (state_q == IDLE) begin
                if (bus.step) begin
                    grid_q <= grid_d;
                    gen_q  <= gen_d;
                    tick_q <= 1'b1;
                end
            end else if (pre_q == bus.period) begin
                pre_q <= '0;
                if (bus.auto_halt && (still || dead)) begin
                    state_q <= IDLE;
                end else begin
                    grid_q <= grid_d;
                    gen_q  <= gen_d;
                    tick_q <= 1'b1;
                end
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    assign bus.grid      = grid_q;
    assign bus.gen_count = gen_q;
    assign bus.gen_tick  = tick_q;
    assign bus.running   = (state_q == RUN);
    assign bus.stable    = stable_q;
    assign bus.extinct   = extinct_q;
endmodule

// File: doc/life_engine.md
# life_engine

Parametrised Conway Game-of-Life engine for a ROWS×COLS cell array, replacing the fixed 8×8 always-evolving loop. It loads a seed (typically from the LFSR), then runs free with a programmable generation period or single-steps on request. It selects toroidal or dead-cell boundaries, counts generations, and detects still-life and extinction so the display/control layer can halt or reseed.

## Interface
- ROWS, 8, grid rows (≥3)
- COLS, 8, grid columns (≥3)
- WRAP, 1, 1 = toroidal edges, 0 = cells outside the grid are dead
- PER_W, 8, width of period input
- GEN_W, 16, width of generation counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- seed  in  ROWS*COLS  initial grid; bit r*COLS+c = cell (row r, col c)
- load  in  1  capture seed into grid
- start  in  1  enter free-run
- stop  in  1  leave free-run
- step  in  1  advance exactly one generation (IDLE only)
- period  in  PER_W  extra cycles between generations in RUN (0 = every cycle)
- auto_halt  in  1  in RUN, drop to IDLE when stable or extinct
- grid  out  ROWS*COLS  current generation (registered)
- gen_count  out  GEN_W  generations since last load, saturating
- gen_tick  out  1  one-cycle pulse, high in the cycle a new generation first appears on grid
- running  out  1  high in RUN
- stable  out  1  last computed next-state equalled current grid
- extinct  out  1  grid all zero

## Operation
- Rule B3/S23: dead cell with exactly 3 live neighbours is born; live cell with 2 or 3 survives; all others die. 8-neighbourhood; neighbour count 0..8 on 4 bits, no overflow.
- WRAP=1: row/col indices taken modulo ROWS/COLS. WRAP=0: out-of-range neighbours read 0.
- Next-state computed combinationally from grid; the grid register is the only cell storage.
- States: IDLE, RUN. Reset → IDLE.
- Command priority each cycle: load > stop > start > step.
- load (any state): grid←seed, gen_count←0, prescaler←0, state→IDLE, gen_tick=0. stable/extinct recomputed from the new grid on the following edge.
- IDLE: start → RUN, prescaler←0. step → one generation, stays IDLE. step ignored in RUN.
- RUN: prescaler counts 0..period; at period, advance one generation, prescaler←0. stop → IDLE, no generation that cycle.
- Advance: grid←next, gen_count←gen_count+1, saturating at 2^GEN_W−1; gen_tick pulses.
- stable, extinct: registered every cycle from the current grid (stable = next==grid; extinct = grid==0). Both valid one cycle after any grid change.
- auto_halt=1 in RUN: when stable or extinct is high at a tick point, do not advance and go to IDLE. gen_count does not increment.
- period changes take effect at the next prescaler comparison.

## Timing
- Reset values: grid=0, gen_count=0, gen_tick=0, running=0, stable=1, extinct=1, state IDLE, prescaler 0.
- load sampled at edge k: grid=seed after edge k.
- step at edge k (IDLE): new grid and gen_tick after edge k.
- start at edge k: running=1 after edge k. First generation at edge k+period+1; subsequent ones every period+1 cycles.
- stop at edge k: running=0 after edge k.
- reset deasserted mid-run restarts cleanly in IDLE with grid=0.
- Simultaneous load+start: only the load takes effect; the engine stays IDLE.

## Test plan
- Blinker, 8×8, WRAP=0: load cells (3,2),(3,3),(3,4); start, period=0 → grid alternates with vertical (2,3),(3,3),(4,3) every cycle; gen_tick held high; stable=0.
- Glider on 8×8 torus (WRAP=1), period=3 → gen_tick every 4 cycles; after 32 generations grid equals seed; gen_count=32.
- Block still life (2×2 at origin), WRAP=0, auto_halt=1, start → stable=1 one cycle after load; RUN drops to IDLE at the first tick; gen_count=0.
- Single live cell, auto_halt=1, start, period=0 → after 1 generation grid=0, extinct=1; next tick halts; gen_count=1.
- Step in IDLE 5 times, then load asserted with start the same cycle → grid=seed, gen_count=0, running=0.
- Reset asserted asynchronously mid-RUN with gen_count=200 → outputs return to reset values immediately, without waiting for a clock edge; first edge after release is IDLE. Saturation check with GEN_W=4: 20 steps → gen_count=15.
